mdu: RTL and testbench

//   Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU.

---
 rtl/mdu.sv | 170 +++++++++++++++++
 tb/tb_mdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU with HI/LO result registers.
// A 32-cycle shift-add / restoring-divide core with a final sign-fix cycle; busy stalls the pipeline.
module mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned AW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             res_neg_q, res_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             divzero_q, divzero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic [AW-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand magnitudes for signed ops; unsigned ops pass raw values.
   always_comb begin
      a_neg = ~op[0] & srca[WIDTH-1];
      b_neg = ~op[0] & srcb[WIDTH-1];
      abs_a = a_neg ? WIDTH'(-srca) : srca;
      abs_b = b_neg ? WIDTH'(-srcb) : srcb;
   end

   // Datapath: mult accumulates into the upper half while shifting the multiplier out of the
   // lower half; div shifts the partial remainder left and trial-subtracts the divisor.
   always_comb begin
      mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
      div_trial = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
      prod_fix  = res_neg_q ? AW'(-acc_q) : acc_q;
      quo_fix   = res_neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix   = rem_neg_q ? WIDTH'(-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      opb_d     = opb_q;
      dvd_d     = dvd_q;
      acc_d     = acc_q;
      done_d    = 1'b0;
      divzero_d = divzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               cnt_d     = '0;
               is_div_d  = op[1];
               res_neg_d = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               dz_d      = op[1] & (srcb == '0);
               dvd_d     = srca;
               divzero_d = 1'b0;
               opb_d     = op[1] ? abs_b : abs_a;
               acc_d     = {WIDTH'(0), (op[1] ? abs_a : abs_b)};
            end else begin
               if (wr_hi) hi_d = wdata;
               if (wr_lo) lo_d = wdata;
            end
         end
         RUN: begin
            if (!is_div_q) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (div_trial[WIDTH]) begin
               acc_d = {acc_q[AW-2:0], 1'b0};
            end else begin
               acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = prod_fix[AW-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
               hi_d      = dvd_q;
               lo_d      = '1;
               divzero_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         opb_q     <= '0;
         dvd_q     <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         opb_q     <= opb_d;
         dvd_q     <= dvd_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign divzero = divzero_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes reference results, a monitor pops them on done.
module tb_mdu;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srca, srcb;
   logic        wr_hi, wr_lo;
   logic [31:0] wdata;
   logic        busy, done, divzero;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   logic [64:0] sb_q[$];
   logic [64:0] last_exp;

   mdu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {divzero, hi, lo} from plain integer arithmetic.
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] q, r;
      case (o)
         2'd0: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            return {1'b0, p};
         end
         2'd1: begin
            p = 64'(a) * 64'(b);
            return {1'b0, p};
         end
         2'd2: begin
            if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
            return {1'b0, r, q};
         end
         default: begin
            if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge clk);
         if (!reset && done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done hi=%h lo=%h expected no result", hi, lo);
            end else begin
               e = sb_q.pop_front();
               chk("result_hi", hi, e[63:32]);
               chk("result_lo", lo, e[31:0]);
               chk("result_divzero", 32'(divzero), 32'(e[64]));
            end
         end
      end
   end

   // Issue one op at the current negedge and wait (bounded) for its done pulse.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
      int cyc = 0;
      int busy_cnt = 0;
      bit seen = 0;
      start = 1'b1; op = o; srca = a; srcb = b;
      last_exp = model(o, a, b);
      sb_q.push_back(last_exp);
      while (cyc < 40 && !seen) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            op = ~o; srca = $urandom; srcb = $urandom;
            chk("done_pulse_width", 32'(done), 32'd0);
            chk("divzero_cleared", 32'(divzero), 32'd0);
         end
         if (poke && cyc == 5) begin
            start = 1'b1; op = 2'd3; srca = 32'd9; srcb = 32'd4;
            wr_hi = 1'b1; wdata = 32'hDEADBEEF;
         end
         if (poke && cyc == 6) begin
            start = 1'b0; wr_hi = 1'b0;
         end
         if (busy) busy_cnt++;
         if (done) seen = 1;
      end
      chk("latency", 32'(cyc), 32'd34);
      chk("busy_cycles", 32'(busy_cnt), 32'd33);
   endtask

   initial begin
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 2'd0; srca = '0; srcb = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_op(2'd0, 32'hFFFFFFFF, 32'd2, 0);
      run_op(2'd1, 32'hFFFFFFFF, 32'd2, 0);
      run_op(2'd3, 32'd7, 32'd2, 0);
      run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'd3, 32'd5, 32'd0, 0);
      chk("divzero_set", 32'(divzero), 32'd1);
      run_op(2'd0, 32'd3, 32'hFFFFFFFF, 0);

      // Reset mid-operation abandons the op and clears everything immediately.
      start = 1'b1; op = 2'd0; srca = 32'h12345; srcb = 32'h6789;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_hi", hi, 32'd0);
      chk("midreset_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      run_op(2'd1, 32'd3, 32'd4, 0);

      // Start and MTHI while busy are both ignored.
      run_op(2'd0, 32'h00010003, 32'hFFFF0002, 1);
      repeat (45) @(negedge clk);
      wr_hi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      wr_hi = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo_kept", lo, last_exp[31:0]);
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_5A5A;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mthilo_hi", hi, 32'hA5A5_5A5A);
      chk("mthilo_lo", lo, 32'hA5A5_5A5A);

      // Randomized ops, back-to-back on the done cycle.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: rb = 32'h0;
            1: rb = 32'hFFFFFFFF;
            2: rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         run_op(2'($urandom_range(0, 3)), ra, rb, 0);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
